// File: rtl/eth_echo_engine.sv
// Ethernet echo responder: buffers one inbound frame, filters on destination MAC and
// ethertype, and replays accepted frames with swapped addresses on an AXI-style byte stream.
module eth_echo_engine #(
  parameter int          MTU          = 1518,
  parameter int          ADDR_W       = 11,
  parameter logic [47:0] MY_ADDR      = 48'hb8_27_eb_a4_30_73,
  parameter logic [15:0] ECHO_ETYPE   = 16'h1234,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_last,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] echo_count,
  output logic [CNT_W-1:0] drop_count
);

  // Handshake: a byte moves when tx_valid && tx_ready at a rising clk edge; while
  // tx_valid is high and tx_ready low, tx_data and tx_last hold. rx has no backpressure.

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_TX      = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam int                  LW       = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]   LAST_PTR = ADDR_W'(MTU - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [5:0][7:0]     MY_BYTES = MY_ADDR;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic               frame_en_q, frame_en_d;
  logic [13:0][7:0]   hdr_q, hdr_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [LW-1:0]      s1_idx_q, s1_idx_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_last_q, tx_last_d;
  logic [CNT_W-1:0]   echo_q, echo_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               in_frame_q, in_frame_d;

  logic [7:0]         mem [0:MTU-1];
  logic [7:0]         rd_data_q;
  logic               mem_we, mem_re;

  logic               out_ready, s1_adv, s1_free;
  logic               drop_inc, echo_inc;
  logic [47:0]        dst_v;
  logic [15:0]        etype_v;
  logic               fe_v, accept_v;
  logic [3:0]         sel;
  logic [7:0]         s1_byte;

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_last    = tx_last_q;
  assign busy       = (state_q != ST_RX);
  assign echo_count = echo_q;
  assign drop_count = drop_q;

  // Buffer RAM; the read register only loads on a fetch so a stalled byte is preserved.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= rx_data;
    if (mem_re) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_comb begin
    sel     = s1_idx_q[3:0];
    s1_byte = rd_data_q;
    if (s1_idx_q < LW'(6)) begin
      s1_byte = hdr_q[4'(sel + 4'd6)];
    end else if (s1_idx_q < LW'(12)) begin
      s1_byte = MY_BYTES[3'(4'd11 - sel)];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    frame_en_d = frame_en_q;
    hdr_d      = hdr_q;
    len_d      = len_q;
    rd_ptr_d   = rd_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    in_frame_d = in_frame_q;
    echo_d     = echo_q;
    drop_d     = drop_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    drop_inc   = 1'b0;
    echo_inc   = 1'b0;
    dst_v      = '0;
    etype_v    = '0;
    fe_v       = 1'b0;
    accept_v   = 1'b0;
    out_ready  = !tx_valid_q || tx_ready;
    s1_adv     = s1_valid_q && out_ready;
    s1_free    = !s1_valid_q || out_ready;

    case (state_q)
      ST_RX: begin
        if (rx_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == '0) frame_en_d = enable;
          if (wr_ptr_q < ADDR_W'(14)) hdr_d[wr_ptr_q[3:0]] = rx_data;
          // Decide on the updated header so a 14-byte frame sees its last etype byte.
          dst_v    = {hdr_d[0], hdr_d[1], hdr_d[2], hdr_d[3], hdr_d[4], hdr_d[5]};
          etype_v  = {hdr_d[12], hdr_d[13]};
          fe_v     = (wr_ptr_q == '0) ? enable : frame_en_q;
          accept_v = fe_v && (wr_ptr_q >= ADDR_W'(13)) && (etype_v == ECHO_ETYPE) &&
                     ((dst_v == MY_ADDR) || (ACCEPT_BCAST && (dst_v == 48'hffff_ffff_ffff)));
          if (rx_last) begin
            wr_ptr_d = '0;
            if (accept_v) begin
              len_d    = LW'(wr_ptr_q) + LW'(1);
              rd_ptr_d = '0;
              state_d  = ST_TX;
            end else begin
              drop_inc = 1'b1;
            end
          end else if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            drop_inc = 1'b1;
            state_d  = ST_DISCARD;
          end
        end
      end

      ST_TX: begin
        if ((rd_ptr_q < len_q) && s1_free) begin
          mem_re     = 1'b1;
          rd_ptr_d   = rd_ptr_q + LW'(1);
          s1_valid_d = 1'b1;
          s1_idx_d   = rd_ptr_q;
        end else if (s1_adv) begin
          s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
          tx_valid_d = 1'b1;
          tx_data_d  = s1_byte;
          tx_last_d  = (s1_idx_q == len_q - LW'(1));
        end else if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end

        if (rx_valid) begin
          if (rx_last) begin
            drop_inc   = 1'b1;
            in_frame_d = 1'b0;
          end else begin
            in_frame_d = 1'b1;
          end
        end

        if (tx_valid_q && tx_ready && tx_last_q) begin
          echo_inc   = 1'b1;
          state_d    = in_frame_d ? ST_DISCARD : ST_RX;
          in_frame_d = 1'b0;
          wr_ptr_d   = '0;
        end
      end

      ST_DISCARD: begin
        if (rx_valid && rx_last) begin
          state_d  = ST_RX;
          wr_ptr_d = '0;
        end
      end

      default: state_d = ST_RX;
    endcase

    if (drop_inc && (drop_q != CNT_MAX)) drop_d = drop_q + 1'b1;
    if (echo_inc && (echo_q != CNT_MAX)) echo_d = echo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RX;
      wr_ptr_q   <= '0;
      frame_en_q <= 1'b0;
      hdr_q      <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
      in_frame_q <= 1'b0;
      echo_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      frame_en_q <= frame_en_d;
      hdr_q      <= hdr_d;
      len_q      <= len_d;
      rd_ptr_q   <= rd_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
      in_frame_q <= in_frame_d;
      echo_q     <= echo_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_eth_echo_engine.sv
// Bench for eth_echo_engine: frame-level reference model feeds an expected-byte queue,
// a monitor pops it on every tx handshake; a second instance runs with broadcast disabled.
module tb_eth_echo_engine;

  localparam int          MTU   = 1518;
  localparam logic [47:0] MY    = 48'hb8_27_eb_a4_30_73;
  localparam logic [15:0] ETYPE = 16'h1234;

  logic        clk, rst, enable, rx_valid, rx_last, tx_ready;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_last, busy;
  logic [7:0]  tx_data;
  logic [15:0] echo_count, drop_count;
  logic        tx_valid_nb, tx_last_nb, busy_nb;
  logic [7:0]  tx_data_nb;
  logic [15:0] echo_count_nb, drop_count_nb;

  eth_echo_engine #(.MTU(MTU), .ADDR_W(11), .MY_ADDR(MY), .ECHO_ETYPE(ETYPE),
                    .ACCEPT_BCAST(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_last(rx_last), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .echo_count(echo_count), .drop_count(drop_count));

  eth_echo_engine #(.MTU(MTU), .ADDR_W(11), .MY_ADDR(MY), .ECHO_ETYPE(ETYPE),
                    .ACCEPT_BCAST(1'b0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst(rst), .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_last(rx_last), .tx_valid(tx_valid_nb), .tx_data(tx_data_nb), .tx_last(tx_last_nb),
    .tx_ready(tx_ready), .busy(busy_nb), .echo_count(echo_count_nb),
    .drop_count(drop_count_nb));

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  frame_q[$];
  int          exp_echo = 0, exp_drop = 0, nb_echo = 0, nb_drop = 0;
  int          pop_cnt = 0;
  int          rdy_mode = 0;
  int          rdy_cnt = 0;
  logic [3:0]  rdy_pat = 4'b1001;
  logic [47:0] my_v = MY;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_cnt++;
      case (rdy_mode)
        1:       tx_ready = rdy_pat[rdy_cnt % 4];
        2:       tx_ready = 1'($urandom_range(0, 1));
        3:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic       stall_prev;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] e;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            check("tx_unexpected", {tx_last, tx_data}, 64'h1ff);
            if ({tx_last, tx_data} == 9'h1ff) begin
              n_fail++;
              $display("FAIL tx_unexpected: actual=%0h required=no byte", {tx_last, tx_data});
            end
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {tx_last, tx_data}, e);
            pop_cnt++;
          end
        end
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
    end
  end

  // reference model: frame-level accept rule and rewritten byte stream
  function automatic bit model_accept(input bit en, input bit bcast_ok);
    int n;
    logic [47:0] dst;
    logic [15:0] et;
    n = frame_q.size();
    if (!en || n < 14 || n > MTU) return 1'b0;
    dst = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    et  = {frame_q[12], frame_q[13]};
    return (et == ETYPE) && ((dst == MY) || (bcast_ok && dst == 48'hffff_ffff_ffff));
  endfunction

  task automatic expect_frame(input bit en);
    int n;
    logic [7:0] b;
    n = frame_q.size();
    if (model_accept(en, 1'b1)) begin
      exp_echo++;
      for (int i = 0; i < n; i++) begin
        if (i < 6)       b = frame_q[6 + i];
        else if (i < 12) b = my_v[8 * (11 - i) +: 8];
        else             b = frame_q[i];
        exp_q.push_back({(i == n - 1), b});
      end
    end else begin
      exp_drop++;
    end
    if (model_accept(en, 1'b0)) nb_echo++;
    else                        nb_drop++;
  endtask

  task automatic make_frame(input int kind, input int len);
    logic [47:0] dst;
    logic [15:0] et;
    frame_q.delete();
    if (kind == 4) begin
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
    end else begin
      dst = MY;
      et  = ETYPE;
      if (kind == 1) dst = 48'hffff_ffff_ffff;
      if (kind == 2) et  = 16'h0800;
      if (kind == 3) dst = MY ^ 48'h1;
      for (int i = 0; i < 6; i++) frame_q.push_back(dst[8 * (5 - i) +: 8]);
      frame_q.push_back(8'h02);
      for (int i = 0; i < 5; i++) frame_q.push_back(8'($urandom));
      frame_q.push_back(et[15:8]);
      frame_q.push_back(et[7:0]);
      for (int i = 14; i < len; i++) frame_q.push_back(8'($urandom));
    end
  endtask

  // rx driver: enable matters only on byte 0, so it is scrambled afterwards
  task automatic drive_frame(input bit en, input bit gaps);
    int n;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_data  = frame_q[i];
      rx_last  = (i == n - 1);
      enable   = (i == 0) ? en : 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((busy || busy_nb || exp_q.size() != 0) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({name, "_timeout"}, 64'(t >= 6000), 64'd0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_echo"},    64'(echo_count),    64'(exp_echo));
    check({name, "_drop"},    64'(drop_count),    64'(exp_drop));
    check({name, "_nb_echo"}, 64'(echo_count_nb), 64'(nb_echo));
    check({name, "_nb_drop"}, 64'(drop_count_nb), 64'(nb_drop));
  endtask

  task automatic run_frame(input string name, input int kind, input int len,
                           input bit en, input bit gaps);
    make_frame(kind, len);
    expect_frame(en);
    drive_frame(en, gaps);
    wait_idle(name);
    check_counts(name);
  endtask

  initial begin
    int base;
    int t;
    rst = 1'b1;
    enable = 1'b1;
    rx_valid = 1'b0;
    rx_last = 1'b0;
    rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_last",  64'(tx_last),  64'd0);
    check("rst_tx_data",  64'(tx_data),  64'd0);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_echo",     64'(echo_count), 64'd0);
    check("rst_drop",     64'(drop_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 60-byte reference frame with exact output latency
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(my_v[8 * (5 - i) +: 8]);
    frame_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) frame_q.push_back(8'h00);
    frame_q.push_back(8'h01);
    frame_q.push_back(8'h12);
    frame_q.push_back(8'h34);
    for (int i = 0; i < 46; i++) frame_q.push_back(8'(i));
    expect_frame(1'b1);
    drive_frame(1'b1, 1'b0);
    @(negedge clk);
    check("lat_cycle0", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle1", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check("lat_cycle2", 64'(tx_valid), 64'd1);
    wait_idle("ref60");
    check_counts("ref60");

    run_frame("bad_etype", 2, 60, 1'b1, 1'b0);
    run_frame("bcast",     1, 60, 1'b1, 1'b0);
    run_frame("short10",   4, 10, 1'b1, 1'b0);
    run_frame("len14",     0, 14, 1'b1, 1'b0);
    run_frame("overlen",   0, MTU + 1, 1'b1, 1'b0);
    run_frame("after_ovl", 0, 60, 1'b1, 1'b0);
    run_frame("mtu",       0, MTU, 1'b1, 1'b0);
    run_frame("en_off",    0, 60, 1'b0, 1'b0);

    // stall pattern 1,0,0,1
    rdy_mode = 1;
    run_frame("stall64", 0, 64, 1'b1, 1'b0);
    rdy_mode = 0;

    // second frame lands while the first is held by tx_ready=0
    rdy_mode = 3;
    make_frame(0, 64);
    expect_frame(1'b1);
    drive_frame(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    make_frame(0, 64);
    exp_drop++;
    nb_drop++;
    drive_frame(1'b1, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("ovl_busy",     64'(busy),     64'd1);
    check("ovl_tx_valid", 64'(tx_valid), 64'd1);
    check("ovl_drop",     64'(drop_count), 64'(exp_drop));
    rdy_mode = 0;
    wait_idle("overlap");
    check_counts("overlap");

    // reset while transmitting
    base = pop_cnt;
    make_frame(0, 64);
    expect_frame(1'b1);
    drive_frame(1'b1, 1'b0);
    t = 0;
    while (pop_cnt < base + 20 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("midrst_reach", 64'(t >= 500), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", 64'(tx_valid),   64'd0);
    check("midrst_echo",     64'(echo_count), 64'd0);
    check("midrst_drop",     64'(drop_count), 64'd0);
    check("midrst_busy",     64'(busy),       64'd0);
    exp_q.delete();
    exp_echo = 0;
    exp_drop = 0;
    nb_echo  = 0;
    nb_drop  = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame("post_rst", 0, 48, 1'b1, 1'b0);

    // randomized mix
    for (int k = 0; k < 30; k++) begin
      int kind;
      int len;
      bit en;
      kind = $urandom_range(0, 5);
      len  = (kind == 4) ? $urandom_range(1, 13) : $urandom_range(14, 90);
      en   = (kind != 5);
      if (kind == 5) kind = 0;
      rdy_mode = $urandom_range(0, 2);
      run_frame("rand", kind, len, en, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
